// File: rtl/dbg_log_pkg.sv
// rtl/dbg_log_pkg.sv - shared channel ids, beat record and round-robin pick for the debug log merger
package dbg_log_pkg;

    localparam int NUM_LOG_CH = 5;
    localparam int LOG_CH_W   = 3;
    localparam int LOG_CNT_W  = LOG_CH_W + 1;
    localparam int LOG_DATA_W = 64;
    localparam int LOG_DEST_W = 16;
    localparam int LOG_TS_W   = 32;

    typedef enum logic [LOG_CH_W-1:0] {
        LOG_RDATA  = 3'd0,
        LOG_WDATA  = 3'd1,
        LOG_RADDR  = 3'd2,
        LOG_AWADDR = 3'd3,
        LOG_RESP   = 3'd4
    } log_ch_e;

    typedef struct packed {
        logic [LOG_DATA_W-1:0] data;
        logic [LOG_DEST_W-1:0] dest;
        logic [LOG_TS_W-1:0]   ts;
    } log_beat_t;

    // Searches from last+1 upward; iterating from the far end lets the nearest requester overwrite.
    function automatic logic [LOG_CH_W-1:0] rr_pick(input logic [NUM_LOG_CH-1:0] req,
                                                    input logic [LOG_CH_W-1:0]   last);
        logic [LOG_CNT_W-1:0] cand;
        logic [LOG_CH_W-1:0]  sel;
        sel = last;
        for (int i = NUM_LOG_CH; i >= 1; i--) begin
            cand = {1'b0, last} + LOG_CNT_W'(i);
            if (cand >= LOG_CNT_W'(NUM_LOG_CH)) begin
                cand = cand - LOG_CNT_W'(NUM_LOG_CH);
            end
            if (req[cand[LOG_CH_W-1:0]]) begin
                sel = cand[LOG_CH_W-1:0];
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/log_hold_reg.sv
// rtl/log_hold_reg.sv - one-entry per-channel beat buffer with acceptance timestamp
module log_hold_reg #(
    parameter int DATA_WIDTH = 64,
    parameter int DEST_WIDTH = 16,
    parameter int TS_WIDTH   = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic [DEST_WIDTH-1:0] in_dest_i,
    input  logic [TS_WIDTH-1:0]   ts_i,
    input  logic                  release_i,
    output logic                  hv_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [DEST_WIDTH-1:0] dest_o,
    output logic [TS_WIDTH-1:0]   ts_o
);

    logic                  hv_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DEST_WIDTH-1:0] dest_q;
    logic [TS_WIDTH-1:0]   ts_q;

    // Releasing this cycle frees the slot, so a reload can land on the same edge.
    assign in_ready_o = ~rst_i & (~hv_q | release_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hv_q   <= 1'b0;
            data_q <= '0;
            dest_q <= '0;
            ts_q   <= '0;
        end else if (in_valid_i && in_ready_o) begin
            hv_q   <= 1'b1;
            data_q <= in_data_i;
            dest_q <= in_dest_i;
            ts_q   <= ts_i;
        end else if (release_i) begin
            hv_q   <= 1'b0;
        end
    end

    assign hv_o   = hv_q;
    assign data_o = data_q;
    assign dest_o = dest_q;
    assign ts_o   = ts_q;

endmodule

// File: rtl/dbg_log_arb.sv
// rtl/dbg_log_arb.sv - timestamps five debug log streams and merges them round-robin into one tagged stream
module dbg_log_arb
    import dbg_log_pkg::*;
#(
    parameter int DATA_WIDTH = LOG_DATA_W,
    parameter int DEST_WIDTH = LOG_DEST_W,
    parameter int TS_WIDTH   = LOG_TS_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] log_TDATA_rdata,
    input  logic [DEST_WIDTH-1:0] log_TDEST_rdata,
    input  logic                  log_TVALID_rdata,
    output logic                  log_TREADY_rdata,
    input  logic [DATA_WIDTH-1:0] log_TDATA_wdata,
    input  logic                  log_TVALID_wdata,
    output logic                  log_TREADY_wdata,
    input  logic [DATA_WIDTH-1:0] log_TDATA_raddr,
    input  logic                  log_TVALID_raddr,
    output logic                  log_TREADY_raddr,
    input  logic [DATA_WIDTH-1:0] log_TDATA_awaddr,
    input  logic                  log_TVALID_awaddr,
    output logic                  log_TREADY_awaddr,
    input  logic [DATA_WIDTH-1:0] log_TDATA_resp,
    input  logic                  log_TVALID_resp,
    output logic                  log_TREADY_resp,
    output logic [DATA_WIDTH-1:0] out_TDATA,
    output logic [DEST_WIDTH-1:0] out_TDEST,
    output logic [LOG_CH_W-1:0]   out_TUSER,
    output logic [TS_WIDTH-1:0]   out_TSTAMP,
    output logic                  out_TVALID,
    input  logic                  out_TREADY
);

    logic [TS_WIDTH-1:0]   ts_q;
    logic [LOG_CH_W-1:0]   ptr_q;
    logic                  ov_q;
    logic [DATA_WIDTH-1:0] odata_q;
    logic [DEST_WIDTH-1:0] odest_q;
    logic [LOG_CH_W-1:0]   ouser_q;
    logic [TS_WIDTH-1:0]   ots_q;

    logic [DATA_WIDTH-1:0] in_data [NUM_LOG_CH];
    logic [DEST_WIDTH-1:0] in_dest [NUM_LOG_CH];
    logic [NUM_LOG_CH-1:0] in_valid;
    logic [NUM_LOG_CH-1:0] in_ready;

    logic [DATA_WIDTH-1:0] hd_data [NUM_LOG_CH];
    logic [DEST_WIDTH-1:0] hd_dest [NUM_LOG_CH];
    logic [TS_WIDTH-1:0]   hd_ts   [NUM_LOG_CH];
    logic [NUM_LOG_CH-1:0] hv;

    logic                  out_load;
    logic [LOG_CH_W-1:0]   sel_ch;
    logic [NUM_LOG_CH-1:0] grant;

    assign in_data[0] = log_TDATA_rdata;
    assign in_data[1] = log_TDATA_wdata;
    assign in_data[2] = log_TDATA_raddr;
    assign in_data[3] = log_TDATA_awaddr;
    assign in_data[4] = log_TDATA_resp;
    assign in_valid   = {log_TVALID_resp, log_TVALID_awaddr, log_TVALID_raddr,
                         log_TVALID_wdata, log_TVALID_rdata};
    assign {log_TREADY_resp, log_TREADY_awaddr, log_TREADY_raddr,
            log_TREADY_wdata, log_TREADY_rdata} = in_ready;

    always_comb begin
        sel_ch   = rr_pick(hv, ptr_q);
        out_load = (|hv) & (~ov_q | out_TREADY);
        grant    = out_load ? (NUM_LOG_CH'(1) << sel_ch) : '0;
    end

    for (genvar c = 0; c < NUM_LOG_CH; c++) begin : g_ch
        // Only the rdata stream carries a destination.
        assign in_dest[c] = (c == 0) ? log_TDEST_rdata : '0;

        log_hold_reg #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEST_WIDTH (DEST_WIDTH),
            .TS_WIDTH   (TS_WIDTH)
        ) u_hold (
            .clk_i      (clk),
            .rst_i      (rst),
            .in_valid_i (in_valid[c]),
            .in_ready_o (in_ready[c]),
            .in_data_i  (in_data[c]),
            .in_dest_i  (in_dest[c]),
            .ts_i       (ts_q),
            .release_i  (grant[c]),
            .hv_o       (hv[c]),
            .data_o     (hd_data[c]),
            .dest_o     (hd_dest[c]),
            .ts_o       (hd_ts[c])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ts_q    <= '0;
            ptr_q   <= LOG_RESP;
            ov_q    <= 1'b0;
            odata_q <= '0;
            odest_q <= '0;
            ouser_q <= '0;
            ots_q   <= '0;
        end else begin
            ts_q <= ts_q + TS_WIDTH'(1);
            if (out_load) begin
                ov_q    <= 1'b1;
                odata_q <= hd_data[sel_ch];
                odest_q <= hd_dest[sel_ch];
                ouser_q <= sel_ch;
                ots_q   <= hd_ts[sel_ch];
                ptr_q   <= sel_ch;
            end else if (out_TREADY) begin
                ov_q    <= 1'b0;
            end
        end
    end

    assign out_TVALID = ov_q;
    assign out_TDATA  = odata_q;
    assign out_TDEST  = odest_q;
    assign out_TUSER  = ouser_q;
    assign out_TSTAMP = ots_q;

endmodule
